// File: rtl/vram_dma.sv
// vram_dma: halts the CPU and copies a block of bytes from one CPU memory page into VRAM.
// One read issues per cycle while vblank is high; each read becomes a VRAM write READ_LATENCY cycles later.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_dma #(
   parameter int VRAM_ADDR_WIDTH = `VRAM_ADDR_WIDTH,
   parameter int READ_LATENCY    = 1,
   parameter int HALT_SETUP      = 1
) (
   input  logic                       cpu_clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [7:0]                 src_page,
   input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
   input  logic [7:0]                 len,
   input  logic                       vblank,
   output logic                       busy,
   output logic                       done,
   output logic                       cpu_halt,
   output logic [15:0]                mem_address,
   output logic                       mem_read_enable,
   input  logic [7:0]                 mem_data_in,
   output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
   output logic [7:0]                 vram_data_out,
   output logic                       vram_write_enable
);

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_XFER, S_DRAIN, S_DONE} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [7:0]                 r_src_page;
   logic [VRAM_ADDR_WIDTH-1:0] r_dst_base;
   logic [8:0]                 r_n;
   logic [8:0]                 r_issued;
   logic [8:0]                 r_written;
   logic [1:0]                 r_halt_cnt;
   logic [READ_LATENCY-1:0]    r_pipe_vld;
   logic [7:0]                 r_pipe_idx [READ_LATENCY];

   logic                       w_rd;
   logic                       w_wr;
   logic                       w_accept;
   logic [8:0]                 w_issued_nxt;
   logic [8:0]                 w_written_nxt;

   assign w_accept      = (r_state == S_IDLE) && start;
   assign w_rd          = (r_state == S_XFER) && vblank && (r_issued != r_n);
   assign w_wr          = r_pipe_vld[READ_LATENCY-1];
   assign w_issued_nxt  = r_issued + {8'd0, w_rd};
   assign w_written_nxt = r_written + {8'd0, w_wr};

   // Completion looks at the post-increment write count so DONE follows the last write directly.
   always_comb begin
      // NOTE: default first so every path assigns the next state and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_HALT;
         S_HALT:  if (r_halt_cnt == 2'(HALT_SETUP - 1)) w_state_nxt = S_XFER;
         S_XFER: begin
            if (w_written_nxt == r_n)     w_state_nxt = S_DONE;
            else if (w_issued_nxt == r_n) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: if (w_written_nxt == r_n) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign busy              = (r_state == S_HALT) || (r_state == S_XFER) || (r_state == S_DRAIN);
   assign cpu_halt          = busy;
   assign done              = (r_state == S_DONE);
   assign mem_read_enable   = w_rd;
   assign mem_address       = w_rd ? {r_src_page, r_issued[7:0]} : 16'd0;
   assign vram_write_enable = w_wr;
   assign vram_address      = w_wr ? r_dst_base + VRAM_ADDR_WIDTH'(r_pipe_idx[READ_LATENCY-1])
                                   : '0;
   assign vram_data_out     = w_wr ? mem_data_in : 8'd0;

   always_ff @(posedge cpu_clk) begin
      // NOTE: non-blocking assignments for all sequential state avoid ordering races between blocks.
      if (rst) begin
         r_state    <= S_IDLE;
         r_src_page <= 8'd0;
         r_dst_base <= '0;
         r_n        <= 9'd0;
         r_issued   <= 9'd0;
         r_written  <= 9'd0;
         r_halt_cnt <= 2'd0;
         r_pipe_vld <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_halt_cnt <= (r_state == S_HALT) ? r_halt_cnt + 2'd1 : 2'd0;
         if (w_accept) begin
            r_src_page <= src_page;
            r_dst_base <= dst_base;
            r_n        <= (len == 8'd0) ? 9'd256 : {1'b0, len};
            r_issued   <= 9'd0;
            r_written  <= 9'd0;
         end else begin
            r_issued   <= w_issued_nxt;
            r_written  <= w_written_nxt;
         end
         r_pipe_vld[0] <= w_rd;
         for (int i = 1; i < READ_LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
   end

   // NOTE: the index stages carry no reset; they are only consumed when their valid bit is set.
   always_ff @(posedge cpu_clk) begin
      r_pipe_idx[0] <= r_issued[7:0];
      for (int i = 1; i < READ_LATENCY; i++) r_pipe_idx[i] <= r_pipe_idx[i-1];
   end

endmodule

// File: tb/tb_vram_dma.sv
// Scoreboard bench for vram_dma: expected reads, writes and done pulses are queued by the tests
// and consumed by a negedge monitor; a second instance covers READ_LATENCY=3, HALT_SETUP=2.
`timescale 1ns/1ps

module tb_vram_dma;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, vblank;
   logic [7:0]  src_page, len;
   logic [11:0] dst_base;
   logic        busy, done, cpu_halt, mem_read_enable, vram_write_enable;
   logic [15:0] mem_address;
   logic [7:0]  mem_data_in, vram_data_out;
   logic [11:0] vram_address;

   logic        b_rst, b_start, b_vblank;
   logic [7:0]  b_src_page, b_len;
   logic [11:0] b_dst_base;
   logic        b_busy, b_done, b_cpu_halt, b_mem_read_enable, b_vram_write_enable;
   logic [15:0] b_mem_address;
   logic [7:0]  b_mem_data_in, b_vram_data_out;
   logic [11:0] b_vram_address;

   vram_dma #(.VRAM_ADDR_WIDTH(12)) dut (
      .cpu_clk(clk), .rst(rst), .start(start), .src_page(src_page), .dst_base(dst_base),
      .len(len), .vblank(vblank), .busy(busy), .done(done), .cpu_halt(cpu_halt),
      .mem_address(mem_address), .mem_read_enable(mem_read_enable), .mem_data_in(mem_data_in),
      .vram_address(vram_address), .vram_data_out(vram_data_out),
      .vram_write_enable(vram_write_enable)
   );

   vram_dma #(.VRAM_ADDR_WIDTH(12), .READ_LATENCY(3), .HALT_SETUP(2)) dut_b (
      .cpu_clk(clk), .rst(b_rst), .start(b_start), .src_page(b_src_page), .dst_base(b_dst_base),
      .len(b_len), .vblank(b_vblank), .busy(b_busy), .done(b_done), .cpu_halt(b_cpu_halt),
      .mem_address(b_mem_address), .mem_read_enable(b_mem_read_enable),
      .mem_data_in(b_mem_data_in), .vram_address(b_vram_address),
      .vram_data_out(b_vram_data_out), .vram_write_enable(b_vram_write_enable)
   );

   // Memory models: data = addr[7:0] ^ 0x5A, 0xEE on cycles with no returning read.
   logic [7:0] m0;
   logic [7:0] m1 [3];
   initial begin
      m0 = 8'hEE;
      for (int i = 0; i < 3; i++) m1[i] = 8'hEE;
   end
   always @(posedge clk) begin
      m0    <= mem_read_enable ? (mem_address[7:0] ^ 8'h5A) : 8'hEE;
      m1[0] <= b_mem_read_enable ? (b_mem_address[7:0] ^ 8'h5A) : 8'hEE;
      m1[1] <= m1[0];
      m1[2] <= m1[1];
   end
   assign mem_data_in   = m0;
   assign b_mem_data_in = m1[2];

   typedef struct {
      int          rel;
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t         wr_q [$];
   logic [15:0] rd_q [$];
   int          done_q [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          base = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a read, a write or a done pulse.
   wr_t         e_wr;
   logic [15:0] e_rd;
   int          e_done;
   always @(negedge clk) begin
      if (vram_write_enable) begin
         if (wr_q.size() == 0) check("unexpected_write", 1, 0);
         else begin
            e_wr = wr_q.pop_front();
            check("wr_cycle", cyc - base, e_wr.rel);
            check("wr_addr", vram_address, e_wr.addr);
            check("wr_data", vram_data_out, e_wr.data);
         end
      end else begin
         check("idle_data_zero", vram_data_out, 0);
      end
      if (mem_read_enable) begin
         if (rd_q.size() == 0) check("unexpected_read", 1, 0);
         else begin
            e_rd = rd_q.pop_front();
            check("rd_addr", mem_address, e_rd);
         end
      end
      if (done) begin
         if (done_q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e_done = done_q.pop_front();
            check("done_cycle", cyc - base, e_done);
         end
      end
   end

   // Queue n_rd reads and n_wr writes; reads start at first_rd, skip the paused cycles,
   // and each write follows its read by one cycle. done_rel < 0 means no done pulse.
   task automatic push_block(input logic [7:0] page, input logic [11:0] dst, input int n_rd,
                             input int n_wr, input int first_rd, input int p_lo, input int p_hi,
                             input int done_rel);
      int          r;
      logic [7:0]  idx;
      logic [11:0] a;
      r = first_rd;
      for (int i = 0; i < n_rd; i++) begin
         while (r >= p_lo && r <= p_hi) r++;
         idx = 8'(i);
         rd_q.push_back({page, idx});
         if (i < n_wr) begin
            a = dst + {4'd0, idx};
            wr_q.push_back('{r + 1, a, idx ^ 8'h5A});
         end
         r++;
      end
      if (done_rel >= 0) done_q.push_back(done_rel);
   endtask

   task automatic run(input logic [7:0] page, input logic [11:0] dst, input logic [7:0] ln,
                      input int p_lo, input int p_hi, input int restart, input int rst_at,
                      input int halt_hi, input int ncyc);
      @(posedge clk); #1;
      base = cyc;
      for (int r = 0; r < ncyc; r++) begin
         if (r > 0) begin
            @(posedge clk); #1;
         end
         start    = (r == 0) || (r == restart);
         rst      = (r == rst_at);
         vblank   = !(r >= p_lo && r <= p_hi);
         src_page = page;
         dst_base = dst;
         len      = ln;
         #1;
         if (halt_hi >= 0) begin
            check("cpu_halt", cpu_halt, (r >= 1 && r <= halt_hi));
            check("busy", busy, (r >= 1 && r <= halt_hi));
         end
         if (rst_at >= 0 && r > rst_at && r <= rst_at + 2)
            check("after_reset_outputs", {busy, done, cpu_halt, mem_read_enable, vram_write_enable,
                                          mem_address, vram_address, vram_data_out}, 0);
      end
      start  = 1'b0;
      rst    = 1'b0;
      vblank = 1'b1;
      check("wr_queue_empty", wr_q.size(), 0);
      check("rd_queue_empty", rd_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vblank = 1'b1; src_page = 8'h00; dst_base = 12'h000; len = 8'h00;
      b_rst = 1'b1; b_start = 1'b0; b_vblank = 1'b1; b_src_page = 8'h09; b_dst_base = 12'h345;
      b_len = 8'd1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy, done, cpu_halt, mem_read_enable, vram_write_enable,
                              mem_address, vram_address, vram_data_out}, 0);
      check("reset_outputs_b", {b_busy, b_done, b_cpu_halt, b_mem_read_enable,
                                b_vram_write_enable, b_mem_address, b_vram_address,
                                b_vram_data_out}, 0);
      rst   = 1'b0;
      b_rst = 1'b0;

      // Full 256-byte copy: writes 3..258, done 259, halt 1..258.
      push_block(8'h02, 12'h800, 256, 256, 2, -1, -1, 259);
      run(8'h02, 12'h800, 8'd0, -1, -1, -1, -1, 258, 262);

      // Destination wrap: FFE, FFF, 000, 001.
      push_block(8'h13, 12'hFFE, 4, 4, 2, -1, -1, 7);
      run(8'h13, 12'hFFE, 8'd4, -1, -1, -1, -1, 6, 10);

      // vblank low in 4..6: reads 2,3,7..12, writes 3,4,8..13, done 14.
      push_block(8'h21, 12'h200, 8, 8, 2, 4, 6, 14);
      run(8'h21, 12'h200, 8'd8, 4, 6, -1, -1, 13, 17);

      // start re-pulsed at cycle 10 is ignored.
      push_block(8'h44, 12'h000, 256, 256, 2, -1, -1, 259);
      run(8'h44, 12'h000, 8'd0, -1, -1, 10, -1, 258, 262);

      // rst in cycle 50: reads 2..50, writes 3..50, no done; fresh start at 53 completes at 312.
      push_block(8'h07, 12'h100, 49, 48, 2, -1, -1, -1);
      push_block(8'h07, 12'h100, 256, 256, 55, -1, -1, 312);
      run(8'h07, 12'h100, 8'd0, -1, -1, 53, 50, -1, 316);

      // READ_LATENCY=3, HALT_SETUP=2, len=1: read 3, write 6, done 7.
      @(posedge clk); #1;
      for (int r = 0; r < 10; r++) begin
         if (r > 0) begin
            @(posedge clk); #1;
         end
         b_start = (r == 0);
         #1;
         check("b_read", b_mem_read_enable, (r == 3));
         check("b_write", b_vram_write_enable, (r == 6));
         check("b_done", b_done, (r == 7));
         check("b_busy", b_busy, (r >= 1 && r <= 6));
         if (r == 3) check("b_rd_addr", b_mem_address, 16'h0900);
         if (r == 6) begin
            check("b_wr_addr", b_vram_address, 12'h345);
            check("b_wr_data", b_vram_data_out, 8'h5A);
         end
      end
      b_start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
